// File: rtl/mem_ring_responder.sv
// mem_ring_responder: memory-side endpoint of the coherent cache ring.
// Occupies one registered stage of the main ring. Consumes second-pass line
// reads into a request FIFO and collects write-back bursts into line buffers.
// A single memory engine commits writes ahead of reads and returns read lines
// on the RD return ring, which this block alone drives.
// Optional build macro: MEMRESP_GRANT_EXCL_EN. When it is defined, a second-pass
// noData+exclusive read is answered in place with a GrantExclusive slot.
// WQ_LINES must be at least 2 and RQ_DEPTH must be a power of 2.
//
// Engine states:
//   state   | meaning
//   IDLE    | nothing in progress; picks a ready write first, then a queued read
//   WR_REQ  | write request presented for the oldest ready line buffer
//   WR_DATA | streaming 8 write beats from that buffer on memWNext
//   RD_REQ  | read request presented for the FIFO head line
//   RD_DATA | forwarding 8 read beats to the head requester on the RD ring
module mem_ring_responder #(
    parameter int         RQ_DEPTH = 8,
    parameter int         WQ_LINES = 2,
    parameter logic [3:0] MY_ID    = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SourceIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SourceOut,
    output logic [31:0] RDreturn,
    output logic [3:0]  RDdest,
    output logic        memReq,
    output logic        memWrite,
    output logic [27:0] memLine,
    input  logic        memAck,
    output logic [31:0] memWData,
    input  logic        memWNext,
    input  logic [31:0] memRData,
    input  logic        memRValid,
    output logic        wbOverflow,
    output logic        busy
);

    localparam logic [3:0] SLOT_NULL       = 4'd0;
    localparam logic [3:0] SLOT_ADDRESS    = 4'd1;
    localparam logic [3:0] SLOT_WRITE_DATA = 4'd2;
    localparam logic [3:0] SLOT_GRANT_EXCL = 4'd3;

    localparam int RQ_AW = $clog2(RQ_DEPTH);
    localparam int WQ_AW = (WQ_LINES > 1) ? $clog2(WQ_LINES) : 1;
    localparam logic [RQ_AW:0] RQ_FULL_COUNT = (RQ_AW + 1)'(RQ_DEPTH);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA} engState_t;

    engState_t state, nextState;
    logic [2:0] engBeat;
    logic       beatInc, wrDone, rdDone;

    // Read request FIFO: {requester, line}
    logic [3:0]       rqSrc  [RQ_DEPTH];
    logic [27:0]      rqLine [RQ_DEPTH];
    logic [RQ_AW-1:0] rqWr, rqRd;
    logic [RQ_AW:0]   rqCount;
    logic             rqFull, rqEmpty;

    // Write line buffers, allocated and committed in arrival order
    logic [31:0]         wbData [WQ_LINES][8];
    logic [27:0]         wbLine [WQ_LINES];
    logic [WQ_LINES-1:0] wbValid, wbReady;
    logic [WQ_AW-1:0]    allocPtr, commitPtr, fillIdx;
    logic                fillValid;
    logic [2:0]          fillBeat;

    logic [31:0] nxtRing;
    logic [3:0]  nxtType, nxtSrc;
    logic        pushReq, wdAccept, waAccept, grantHit;
    logic        unusedBits;

    assign unusedBits = ^{MY_ID, RingIn[30:29]};

    assign rqFull  = (rqCount == RQ_FULL_COUNT);
    assign rqEmpty = (rqCount == '0);
    assign busy    = !rqEmpty || (|wbValid) || (state != IDLE);

`ifdef MEMRESP_GRANT_EXCL_EN
    assign grantHit = RingIn[30] & RingIn[29];
`else
    assign grantHit = 1'b0;
`endif

    function automatic logic [WQ_AW-1:0] nextWq(input logic [WQ_AW-1:0] p);
        if (p == WQ_AW'(WQ_LINES - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Ring stage decode: decide what leaves the stage and what is captured
    always_comb begin
        nxtRing  = RingIn;
        nxtType  = SlotTypeIn;
        nxtSrc   = SourceIn;
        pushReq  = 1'b0;
        wdAccept = 1'b0;
        waAccept = 1'b0;
        if (SlotTypeIn == SLOT_ADDRESS) begin
            if (RingIn[28]) begin
                if (!RingIn[31]) begin
                    // first pass only marks the slot so snoops see a full lap
                    nxtRing[31] = 1'b1;
                end else if (grantHit) begin
                    nxtType = SLOT_GRANT_EXCL;
                    nxtRing = {4'd0, RingIn[27:0]};
                end else if (!rqFull) begin
                    nxtType = SLOT_NULL;
                    nxtRing = '0;
                    nxtSrc  = '0;
                    pushReq = 1'b1;
                end
            end else if (!RingIn[31]) begin
                nxtType  = SLOT_NULL;
                nxtRing  = '0;
                nxtSrc   = '0;
                waAccept = 1'b1;
            end
        end else if (SlotTypeIn == SLOT_WRITE_DATA) begin
            nxtType  = SLOT_NULL;
            nxtRing  = '0;
            nxtSrc   = '0;
            wdAccept = 1'b1;
        end
    end

    // Ring output register
    always_ff @(posedge clock) begin
        if (reset) begin
            RingOut     <= '0;
            SlotTypeOut <= SLOT_NULL;
            SourceOut   <= '0;
        end else begin
            RingOut     <= nxtRing;
            SlotTypeOut <= nxtType;
            SourceOut   <= nxtSrc;
        end
    end

    // Read request FIFO storage and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            rqWr    <= '0;
            rqRd    <= '0;
            rqCount <= '0;
        end else begin
            if (pushReq) begin
                rqSrc[rqWr]  <= SourceIn;
                rqLine[rqWr] <= RingIn[27:0];
                rqWr         <= rqWr + 1'b1;
            end
            if (rdDone) rqRd <= rqRd + 1'b1;
            case ({pushReq, rdDone})
                2'b10:   rqCount <= rqCount + 1'b1;
                2'b01:   rqCount <= rqCount - 1'b1;
                default: rqCount <= rqCount;
            endcase
        end
    end

    // Write burst capture into line buffers; a burst whose first beat finds
    // no free buffer is dropped whole and flagged
    always_ff @(posedge clock) begin
        if (reset) begin
            wbValid    <= '0;
            wbReady    <= '0;
            allocPtr   <= '0;
            commitPtr  <= '0;
            fillIdx    <= '0;
            fillValid  <= 1'b0;
            fillBeat   <= '0;
            wbOverflow <= 1'b0;
        end else begin
            if (wrDone) begin
                wbValid[commitPtr] <= 1'b0;
                wbReady[commitPtr] <= 1'b0;
                commitPtr          <= nextWq(commitPtr);
            end
            if (wdAccept) begin
                fillBeat <= fillBeat + 1'b1;
                if (fillValid) begin
                    wbData[fillIdx][fillBeat] <= RingIn;
                end else if (fillBeat == 3'd0) begin
                    if (!wbValid[allocPtr]) begin
                        wbValid[allocPtr]   <= 1'b1;
                        wbData[allocPtr][0] <= RingIn;
                        fillIdx             <= allocPtr;
                        fillValid           <= 1'b1;
                        allocPtr            <= nextWq(allocPtr);
                    end else begin
                        wbOverflow <= 1'b1;
                    end
                end
            end
            if (waAccept) begin
                fillBeat <= '0;
                if (fillValid) begin
                    wbReady[fillIdx] <= 1'b1;
                    wbLine[fillIdx]  <= RingIn[27:0];
                    fillValid        <= 1'b0;
                end
            end
        end
    end

    // Engine state, beat counter and RD return register
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            engBeat  <= '0;
            RDdest   <= '0;
            RDreturn <= '0;
        end else begin
            state <= nextState;
            if (beatInc) engBeat <= engBeat + 1'b1;
            if (state == RD_DATA && memRValid) begin
                RDdest   <= rqSrc[rqRd];
                RDreturn <= memRData;
            end else begin
                RDdest   <= '0;
                RDreturn <= '0;
            end
        end
    end

    // Engine next-state and memory port outputs
    always_comb begin
        nextState = state;
        memReq    = 1'b0;
        memWrite  = 1'b0;
        memLine   = '0;
        memWData  = '0;
        beatInc   = 1'b0;
        wrDone    = 1'b0;
        rdDone    = 1'b0;
        case (state)
            IDLE: begin
                if (wbReady[commitPtr]) nextState = WR_REQ;
                else if (!rqEmpty && !(|wbValid)) nextState = RD_REQ;
            end
            WR_REQ: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                memLine  = wbLine[commitPtr];
                if (memAck) nextState = WR_DATA;
            end
            WR_DATA: begin
                memWData = wbData[commitPtr][engBeat];
                if (memWNext) begin
                    beatInc = 1'b1;
                    if (engBeat == 3'd7) begin
                        wrDone    = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            RD_REQ: begin
                memReq  = 1'b1;
                memLine = rqLine[rqRd];
                if (memAck) nextState = RD_DATA;
            end
            RD_DATA: begin
                if (memRValid) begin
                    beatInc = 1'b1;
                    if (engBeat == 3'd7) begin
                        rdDone    = 1'b1;
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ring_responder.sv
// Directed bench for mem_ring_responder: ring pass/consume behaviour, read and
// write memory transactions, write-before-read ordering, FIFO-full recirculation,
// exclusive grant (build dependent), overflow and mid-burst reset.
module tb_mem_ring_responder;

    localparam logic [3:0] SLOT_NULL       = 4'd0;
    localparam logic [3:0] SLOT_ADDRESS    = 4'd1;
    localparam logic [3:0] SLOT_WRITE_DATA = 4'd2;
    localparam logic [3:0] SLOT_GRANT_EXCL = 4'd3;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn, SourceIn;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut, SourceOut;
    logic [31:0] RDreturn;
    logic [3:0]  RDdest;
    logic        memReq, memWrite;
    logic [27:0] memLine;
    logic        memAck;
    logic [31:0] memWData;
    logic        memWNext;
    logic [31:0] memRData;
    logic        memRValid;
    logic        wbOverflow, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] memModel [8];

    mem_ring_responder dut (
        .clock(clock), .reset(reset),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
        .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
        .RDreturn(RDreturn), .RDdest(RDdest),
        .memReq(memReq), .memWrite(memWrite), .memLine(memLine), .memAck(memAck),
        .memWData(memWData), .memWNext(memWNext),
        .memRData(memRData), .memRValid(memRValid),
        .wbOverflow(wbOverflow), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ringSlot(input logic [3:0] slotType, input logic [3:0] src, input logic [31:0] data);
        SlotTypeIn = slotType;
        SourceIn   = src;
        RingIn     = data;
        tick();
        SlotTypeIn = SLOT_NULL;
        SourceIn   = 4'd0;
        RingIn     = 32'd0;
    endtask

    task automatic writeBurst(input logic [3:0] src, input logic [27:0] line, input logic [31:0] base,
                              output int nulls);
        nulls = 0;
        for (int i = 0; i < 8; i++) begin
            ringSlot(SLOT_WRITE_DATA, src, base + 32'(i));
            if (SlotTypeOut == SLOT_NULL) nulls++;
        end
        ringSlot(SLOT_ADDRESS, src, {4'h0, line});
        if (SlotTypeOut == SLOT_NULL) nulls++;
    endtask

    task automatic waitMemReq(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (memReq) break;
            tick();
        end
        checkVal(tag, 32'(memReq), 32'd1);
    endtask

    task automatic serveWrite(input logic [27:0] line, input logic [31:0] expBase);
        waitMemReq("wr_req_seen");
        checkVal("wr_is_write", 32'(memWrite), 32'd1);
        checkVal("wr_line", 32'(memLine), 32'(line));
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkVal("wr_beat", memWData, expBase + 32'(i));
            memModel[i] = memWData;
            memWNext = 1'b1;
            tick();
        end
        memWNext = 1'b0;
    endtask

    task automatic serveRead(input logic [27:0] line, input logic [3:0] src, input logic [31:0] expBase);
        waitMemReq("rd_req_seen");
        checkVal("rd_is_read", 32'(memWrite), 32'd0);
        checkVal("rd_line", 32'(memLine), 32'(line));
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        for (int i = 0; i < 8; i++) begin
            memRData  = memModel[i];
            memRValid = 1'b1;
            tick();
            checkVal("rd_dest", 32'(RDdest), 32'(src));
            checkVal("rd_data", RDreturn, expBase + 32'(i));
        end
        memRValid = 1'b0;
        memRData  = 32'd0;
        tick();
        checkVal("rd_dest_after", 32'(RDdest), 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int nulls;
        reset = 1'b1; RingIn = '0; SlotTypeIn = SLOT_NULL; SourceIn = '0;
        memAck = 1'b0; memWNext = 1'b0; memRData = '0; memRValid = 1'b0;
        tick(); tick(); tick();

        // Reset state
        checkVal("rst_ring", RingOut, 32'd0);
        checkVal("rst_type", 32'(SlotTypeOut), 32'(SLOT_NULL));
        checkVal("rst_rddest", 32'(RDdest), 32'd0);
        checkVal("rst_memreq", 32'(memReq), 32'd0);
        checkVal("rst_ovf", 32'(wbOverflow), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Read: first pass forwarded marked, second pass consumed and served
        ringSlot(SLOT_ADDRESS, 4'd3, 32'h1000_0040);
        checkVal("rd1_fwd_data", RingOut, 32'h9000_0040);
        checkVal("rd1_fwd_type", 32'(SlotTypeOut), 32'(SLOT_ADDRESS));
        checkVal("rd1_fwd_src", 32'(SourceOut), 32'd3);
        ringSlot(SLOT_ADDRESS, 4'd3, 32'h9000_0040);
        checkVal("rd1_consume_type", 32'(SlotTypeOut), 32'(SLOT_NULL));
        checkVal("rd1_consume_data", RingOut, 32'd0);
        for (int i = 0; i < 8; i++) memModel[i] = 32'hD000_0000 + 32'(i);
        serveRead(28'h40, 4'd3, 32'hD000_0000);
        checkVal("rd1_idle_busy", 32'(busy), 32'd0);

        // Write burst of 8 beats plus address
        writeBurst(4'd2, 28'h55, 32'hA0, nulls);
        checkVal("wr1_nulls", 32'(nulls), 32'd9);
        serveWrite(28'h55, 32'hA0);
        tick();
        checkVal("wr1_busy_drop", 32'(busy), 32'd0);

        // Write still buffered when a read of the same line is queued
        writeBurst(4'd2, 28'h55, 32'hB0, nulls);
        ringSlot(SLOT_ADDRESS, 4'd4, 32'h1000_0055);
        ringSlot(SLOT_ADDRESS, 4'd4, 32'h9000_0055);
        checkVal("ord_read_consumed", 32'(SlotTypeOut), 32'(SLOT_NULL));
        serveWrite(28'h55, 32'hB0);
        serveRead(28'h55, 4'd4, 32'hB0);

        // FIFO full: 9th second-pass read recirculates, consumed after a pop
        for (int i = 0; i < 8; i++) ringSlot(SLOT_ADDRESS, 4'd1, 32'h9000_0100 + 32'(i));
        ringSlot(SLOT_ADDRESS, 4'd6, 32'h9000_0200);
        checkVal("full_fwd_data", RingOut, 32'h9000_0200);
        checkVal("full_fwd_type", 32'(SlotTypeOut), 32'(SLOT_ADDRESS));
        checkVal("full_fwd_src", 32'(SourceOut), 32'd6);
        for (int i = 0; i < 8; i++) memModel[i] = 32'hC0 + 32'(i);
        serveRead(28'h100, 4'd1, 32'hC0);
        ringSlot(SLOT_ADDRESS, 4'd6, 32'h9000_0200);
        checkVal("full_retry_consumed", 32'(SlotTypeOut), 32'(SLOT_NULL));
        for (int i = 1; i < 8; i++) serveRead(28'h100 + 28'(i), 4'd1, 32'hC0);
        serveRead(28'h200, 4'd6, 32'hC0);
        checkVal("full_drained_busy", 32'(busy), 32'd0);

        // noData exclusive read, second pass
        ringSlot(SLOT_ADDRESS, 4'd5, 32'hF000_0010);
`ifdef MEMRESP_GRANT_EXCL_EN
        checkVal("gx_type", 32'(SlotTypeOut), 32'(SLOT_GRANT_EXCL));
        checkVal("gx_src", 32'(SourceOut), 32'd5);
        checkVal("gx_data", RingOut, 32'h10);
        tick(); tick(); tick();
        checkVal("gx_no_memreq", 32'(memReq), 32'd0);
        checkVal("gx_not_busy", 32'(busy), 32'd0);
`else
        checkVal("gx_consumed", 32'(SlotTypeOut), 32'(SLOT_NULL));
        for (int i = 0; i < 8; i++) memModel[i] = 32'hE0 + 32'(i);
        serveRead(28'h10, 4'd5, 32'hE0);
`endif

        // Three bursts with memAck low: third one overflows
        writeBurst(4'd1, 28'h60, 32'h100, nulls);
        writeBurst(4'd1, 28'h61, 32'h200, nulls);
        checkVal("ovf_two_ok", 32'(wbOverflow), 32'd0);
        writeBurst(4'd1, 28'h62, 32'h300, nulls);
        checkVal("ovf_third", 32'(wbOverflow), 32'd1);
        checkVal("ovf_third_nulls", 32'(nulls), 32'd9);
        doReset();
        checkVal("ovf_cleared", 32'(wbOverflow), 32'd0);
        checkVal("ovf_rst_busy", 32'(busy), 32'd0);

        // Reset in the middle of a read return
        ringSlot(SLOT_ADDRESS, 4'd7, 32'h9000_0077);
        waitMemReq("mid_req_seen");
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            memRData = 32'h77 + 32'(i);
            memRValid = 1'b1;
            tick();
        end
        checkVal("mid_dest_active", 32'(RDdest), 32'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkVal("mid_rst_dest", 32'(RDdest), 32'd0);
        checkVal("mid_rst_busy", 32'(busy), 32'd0);
        checkVal("mid_rst_memreq", 32'(memReq), 32'd0);
        tick();
        checkVal("mid_rst_dest_hold", 32'(RDdest), 32'd0);
        memRValid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
